// File: rtl/enc_pkg.sv
// Shared types and constants for the encoder position counter.
// Build option POS_WRAP_EN (see encoder_position_counter.sv) selects wrap versus saturate.
package enc_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PUB  = 1'b1
    } state_t;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, followed by a history flop.
// rise pulses for one clk cycle per synchronised 0->1 transition.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/encoder_position_counter.sv
// Accumulates a bounded signed position from CW/CCW edges and publishes snapshots over valid/ready.
// Define POS_WRAP_EN to wrap at the bounds instead of saturating.
module encoder_position_counter
    import enc_pkg::*;
#(
    parameter int W       = 16,
    parameter int STEP    = 1,
    parameter int MIN_POS = -100,
    parameter int MAX_POS = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                x1,
    input  logic                x2,
    input  logic                clr,
    input  logic                pos_ready,
    output logic signed [W-1:0] pos_out,
    output logic                pos_valid,
    output logic                dir,
    output logic                at_min,
    output logic                at_max,
    output logic                err
);

    localparam logic signed [W:0]   STEP_EXT = STEP[W:0];
    localparam logic signed [W:0]   MIN_EXT  = MIN_POS[W:0];
    localparam logic signed [W:0]   MAX_EXT  = MAX_POS[W:0];
    localparam logic signed [W-1:0] MIN_W    = MIN_POS[W-1:0];
    localparam logic signed [W-1:0] MAX_W    = MAX_POS[W-1:0];

    logic                cw_rise;
    logic                ccw_rise;
    logic signed [W-1:0] pos;
    logic signed [W:0]   pos_ext;
    logic signed [W:0]   sum_cw;
    logic signed [W:0]   sum_ccw;
    state_t              state;
    state_t              next_state;
    logic                load;

    sync_edge_detect u_sync_cw (
        .clk  (clk),
        .rst  (rst),
        .din  (x1),
        .rise (cw_rise)
    );

    sync_edge_detect u_sync_ccw (
        .clk  (clk),
        .rst  (rst),
        .din  (x2),
        .rise (ccw_rise)
    );

    // Sums carry one guard bit so an overshoot is seen before it can wrap in W bits.
    function automatic logic signed [W-1:0] bound_pos(input logic signed [W:0] s);
`ifdef POS_WRAP_EN
        if (s > MAX_EXT) return MIN_W;
        if (s < MIN_EXT) return MAX_W;
`else
        if (s > MAX_EXT) return MAX_W;
        if (s < MIN_EXT) return MIN_W;
`endif
        return s[W-1:0];
    endfunction

    assign pos_ext = {pos[W-1], pos};
    assign sum_cw  = pos_ext + STEP_EXT;
    assign sum_ccw = pos_ext - STEP_EXT;

    // Position update: clr wins over edges; simultaneous edges hold position and flag err.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pos <= '0;
            dir <= DIR_CCW;
            err <= 1'b0;
        end else begin
            if (cw_rise && ccw_rise) begin
                err <= 1'b1;
            end
            if (clr) begin
                pos <= '0;
            end else if (cw_rise && !ccw_rise) begin
                pos <= bound_pos(sum_cw);
                dir <= DIR_CW;
            end else if (ccw_rise && !cw_rise) begin
                pos <= bound_pos(sum_ccw);
                dir <= DIR_CCW;
            end
        end
    end

    assign at_min = (pos == MIN_W);
    assign at_max = (pos == MAX_W);

    // Publish stage: snapshot pos into pos_out whenever it differs from what was last offered.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                if (pos != pos_out) begin
                    load       = 1'b1;
                    next_state = S_PUB;
                end
            end
            S_PUB: begin
                if (pos_ready) begin
                    if (pos != pos_out) begin
                        load = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            pos_out <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                pos_out <= pos;
            end
        end
    end

    assign pos_valid = (state == S_PUB);

endmodule
